// File: rtl/spad_acc.sv
// Scratchpad accumulator: single-cycle read, one-deep write/accumulate stage,
// and a full-array clear sweep that holds off all requests while it runs.
module spad_acc #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 9,
    parameter bit SATURATE      = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     read_req,
    input  logic [ADDR_BITWIDTH-1:0] r_addr,
    output logic [DATA_BITWIDTH-1:0] r_data,
    output logic                     r_valid,
    input  logic                     write_en,
    input  logic                     acc_en,
    input  logic [ADDR_BITWIDTH-1:0] w_addr,
    input  logic [DATA_BITWIDTH-1:0] w_data,
    input  logic                     clear_req,
    output logic                     busy
);

    localparam int DEPTH = 1 << ADDR_BITWIDTH;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    logic signed [DATA_BITWIDTH-1:0] r_mem [DEPTH];

    state_t                          r_state;
    logic                            r_busy;
    logic [ADDR_BITWIDTH-1:0]        r_cnt;
    logic                            r_valid_p1;
    logic [DATA_BITWIDTH-1:0]        r_data_p1;

    logic                            r_wv_p0;
    logic [ADDR_BITWIDTH-1:0]        r_wa_p0;
    logic signed [DATA_BITWIDTH-1:0] r_wd_p0;
    logic                            r_wacc_p0;

    logic                            w_accept;
    logic signed [DATA_BITWIDTH-1:0] w_commit_val;
    logic                            w_mem_we;
    logic [ADDR_BITWIDTH-1:0]        w_mem_addr;
    logic signed [DATA_BITWIDTH-1:0] w_mem_wdata;
    logic                            w_rd_fwd;

    // Signed add one bit wider than the data, then clamp or wrap back to width.
    function automatic logic signed [DATA_BITWIDTH-1:0] sat_add(
        input logic signed [DATA_BITWIDTH-1:0] a,
        input logic signed [DATA_BITWIDTH-1:0] b
    );
        logic signed [DATA_BITWIDTH:0] s;
        s = {a[DATA_BITWIDTH-1], a} + {b[DATA_BITWIDTH-1], b};
        if (SATURATE && (s[DATA_BITWIDTH] != s[DATA_BITWIDTH-1])) begin
            return s[DATA_BITWIDTH] ? {1'b1, {(DATA_BITWIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_BITWIDTH-1){1'b1}}};
        end
        return s[DATA_BITWIDTH-1:0];
    endfunction

    assign w_accept     = !r_busy && !clear_req;
    assign w_commit_val = r_wacc_p0 ? sat_add(r_mem[r_wa_p0], r_wd_p0) : r_wd_p0;

    // The stage register is never loaded while sweeping, so commit and sweep
    // never compete for the single write port.
    assign w_mem_we    = r_wv_p0 || (r_state == ST_CLEAR);
    assign w_mem_addr  = r_wv_p0 ? r_wa_p0 : r_cnt;
    assign w_mem_wdata = r_wv_p0 ? w_commit_val : '0;
    assign w_rd_fwd    = r_wv_p0 && (r_wa_p0 == r_addr);

    assign r_data  = r_data_p1;
    assign r_valid = r_valid_p1;
    assign busy    = r_busy;

    always_ff @(posedge clk) begin
        if (!reset && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Stage p0: accepted write captured here, committed on the next edge.
    always_ff @(posedge clk) begin
        if (w_accept && write_en) begin
            r_wa_p0   <= w_addr;
            r_wd_p0   <= w_data;
            r_wacc_p0 <= acc_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_wv_p0    <= 1'b0;
            r_valid_p1 <= 1'b0;
            r_data_p1  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_req) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            r_wv_p0    <= w_accept && write_en;
            r_valid_p1 <= w_accept && read_req;
            // Stage p1: read result, write-first against a same-edge commit.
            if (w_accept && read_req) begin
                r_data_p1 <= w_rd_fwd ? w_commit_val : r_mem[r_addr];
            end
        end
    end

endmodule

// File: tb/tb_spad_acc.sv
// Directed bench for spad_acc: saturating and wrapping instances share stimulus
// and are checked every cycle against a transaction-level memory model.
module tb_spad_acc;

    localparam int DW    = 16;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, read_req, write_en, acc_en, clear_req;
    logic [AW-1:0] r_addr, w_addr;
    logic [DW-1:0] w_data;
    logic [DW-1:0] rd_s, rd_w;
    logic          rv_s, rv_w, busy_s, busy_w;

    spad_acc #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .read_req(read_req), .r_addr(r_addr),
        .r_data(rd_s), .r_valid(rv_s), .write_en(write_en), .acc_en(acc_en),
        .w_addr(w_addr), .w_data(w_data), .clear_req(clear_req), .busy(busy_s)
    );

    spad_acc #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .read_req(read_req), .r_addr(r_addr),
        .r_data(rd_w), .r_valid(rv_w), .write_en(write_en), .acc_en(acc_en),
        .w_addr(w_addr), .w_data(w_data), .clear_req(clear_req), .busy(busy_w)
    );

    int ntests = 0;
    int nfail  = 0;

    task automatic check(input string name, input int act, input int exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: memory contents as plain integers for each flavour.
    int m_s [DEPTH];
    int m_w [DEPTH];
    bit pv, pacc;
    int pa, pd;
    int busy_left;
    int e_rd_s, e_rd_w;
    bit e_rv;
    bit mdl_ok = 1'b0;

    function automatic int model_acc(input int m, input int d, input bit sat);
        int s = m + d;
        if (sat) begin
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
        end else begin
            if (s > 32767) s -= 65536;
            else if (s < -32768) s += 65536;
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            busy_left = 0;
            pv        = 1'b0;
            e_rv      = 1'b0;
            e_rd_s    = 0;
            e_rd_w    = 0;
            mdl_ok    = 1'b1;
        end else begin
            bit ok;
            ok = (busy_left == 0) && !clear_req;
            if (pv) begin
                m_s[pa] = pacc ? model_acc(m_s[pa], pd, 1'b1) : pd;
                m_w[pa] = pacc ? model_acc(m_w[pa], pd, 1'b0) : pd;
            end
            if (busy_left > 0) begin
                m_s[DEPTH - busy_left] = 0;
                m_w[DEPTH - busy_left] = 0;
                busy_left--;
            end else if (clear_req) begin
                busy_left = DEPTH;
            end
            pv   = ok && write_en;
            pa   = int'(w_addr);
            pd   = $signed(w_data);
            pacc = acc_en;
            if (ok && read_req) begin
                e_rd_s = m_s[r_addr];
                e_rd_w = m_w[r_addr];
                e_rv   = 1'b1;
            end else begin
                e_rv = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_ok) begin
            check("cyc_rdata_sat",  $signed(rd_s), e_rd_s);
            check("cyc_rdata_wrap", $signed(rd_w), e_rd_w);
            check("cyc_rvalid_sat",  int'(rv_s), int'(e_rv));
            check("cyc_rvalid_wrap", int'(rv_w), int'(e_rv));
            check("cyc_busy_sat",  int'(busy_s), int'(busy_left > 0));
            check("cyc_busy_wrap", int'(busy_w), int'(busy_left > 0));
        end
    end

    task automatic idle();
        read_req  = 1'b0;
        write_en  = 1'b0;
        acc_en    = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        idle();
    endtask

    task automatic wr(input int a, input int d, input bit acc);
        write_en = 1'b1;
        w_addr   = a[AW-1:0];
        w_data   = d[DW-1:0];
        acc_en   = acc;
    endtask

    task automatic rd(input int a);
        read_req = 1'b1;
        r_addr   = a[AW-1:0];
    endtask

    task automatic expect_both(input string name, input int exp_s, input int exp_w);
        check({name, "_sat"},  $signed(rd_s), exp_s);
        check({name, "_wrap"}, $signed(rd_w), exp_w);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        int n;
        reset  = 1'b1;
        r_addr = '0;
        w_addr = '0;
        w_data = '0;
        idle();
        tick();
        tick();
        expect_both("reset_rdata", 0, 0);
        check("reset_rvalid", int'(rv_s), 0);
        check("reset_busy", int'(busy_s), 0);
        reset = 1'b0;

        clear_req = 1'b1;
        tick();
        n = 0;
        while (busy_s && n < 600) begin tick(); n++; end
        check("init_clear_done", int'(busy_s), 0);

        // Overwrite then read: valid for one cycle, data held afterwards.
        wr(5, 100, 1'b0); tick();
        rd(5); tick();
        expect_both("ovw_read", 100, 100);
        check("ovw_rvalid", int'(rv_s), 1);
        tick();
        check("ovw_rvalid_drop", int'(rv_s), 0);
        expect_both("ovw_hold", 100, 100);

        // Back-to-back accumulates into one address.
        wr(7, 10, 1'b0); tick();
        wr(7, 3, 1'b1);  tick();
        wr(7, 4, 1'b1);  tick();
        wr(7, 5, 1'b1);  tick();
        rd(7); tick();
        expect_both("acc_chain", 22, 22);

        // Saturate vs wrap at both extremes.
        wr(1, 32760, 1'b0);  tick();
        wr(2, -32760, 1'b0); tick();
        wr(1, 100, 1'b1);    tick();
        wr(2, -100, 1'b1);   tick();
        tick();
        rd(1); tick();
        expect_both("acc_pos_edge", 32767, -32676);
        rd(2); tick();
        expect_both("acc_neg_edge", -32768, 32676);

        // Read on the write's own edge sees old data; next edge is forwarded.
        wr(3, 55, 1'b0); tick();
        rd(3); tick();
        expect_both("fwd_collision", 55, 55);
        wr(4, 66, 1'b0); rd(4); tick();
        expect_both("same_edge_old", 0, 0);
        rd(4); tick();
        expect_both("same_edge_next", 66, 66);

        // Fill, then clear while hammering requests and a second clear_req.
        for (int a = 0; a < DEPTH; a++) begin
            wr(a, a + 1000, 1'b0); tick();
        end
        clear_req = 1'b1; tick();
        n = 0;
        while (busy_s && n < 600) begin
            wr(n % DEPTH, 7, n[0]);
            rd((n * 5) % DEPTH);
            if (n == 50) clear_req = 1'b1;
            tick();
            check("busy_read_ignored", int'(rv_s), 0);
            n++;
        end
        check("busy_cycles", n, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            rd(a); tick();
            expect_both("cleared", 0, 0);
        end

        // Reset mid-sweep at counter 100, with a write committed at the clear edge.
        wr(200, 1234, 1'b0); tick();
        wr(150, 555, 1'b0);  tick();
        wr(50, 444, 1'b0);   tick();
        wr(300, 999, 1'b0); rd(150); tick();
        expect_both("pre_clear_read", 555, 555);
        clear_req = 1'b1; tick();
        repeat (100) tick();
        reset = 1'b1; wr(10, 1, 1'b0); rd(10); tick();
        reset = 1'b0;
        check("abort_busy", int'(busy_s), 0);
        check("abort_rvalid", int'(rv_s), 0);
        expect_both("abort_rdata", 0, 0);
        rd(200); tick(); expect_both("abort_keep200", 1234, 1234);
        rd(300); tick(); expect_both("abort_commit300", 999, 999);
        rd(150); tick(); expect_both("abort_keep150", 555, 555);
        rd(50);  tick(); expect_both("abort_swept50", 0, 0);

        // Pending write dropped by reset.
        wr(400, 4321, 1'b0); tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        rd(400); tick();
        expect_both("reset_drops_pending", 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
